// File: rtl/sfu_out_buffer.sv
// SFU result FWFT queue: entry pushed at edge N is at the head after edge N.
// IN_READY depends only on occupancy, so a full buffer refuses a push even during a pop; OVERRUN is sticky.
module sfu_out_buffer #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic                       IN_VALID,
    input  logic [DW-1:0]              IN_DATA,
    input  logic                       IN_ZERO,
    input  logic                       IN_SFUOP,
    output logic                       IN_READY,
    input  logic                       FLUSH,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [DW-1:0]              OUT_DATA,
    output logic                       OUT_ZERO,
    output logic                       OUT_SFUOP,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       OVERRUN
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          zero;
        logic          sfuop;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overrun_q, overrun_d;
    logic            push, pop;

    assign IN_READY  = (count_q < FULL_CNT);
    assign OUT_VALID = (count_q != '0);
    assign COUNT     = count_q;
    assign OVERRUN   = overrun_q;
    assign OUT_DATA  = mem_q[rd_ptr_q].dat;
    assign OUT_ZERO  = mem_q[rd_ptr_q].zero;
    assign OUT_SFUOP = mem_q[rd_ptr_q].sfuop;

    assign push = IN_VALID && IN_READY;
    assign pop  = OUT_VALID && OUT_READY;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (FLUSH) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            overrun_d = 1'b0;
        end else begin
            // Pointers are AW bits wide, so DEPTH-1 -> 0 wrap is implicit.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (IN_VALID && !IN_READY) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is deliberately unreset; OUT_DATA is meaningless while empty.
    always_ff @(posedge CLK) begin
        if (push && !FLUSH) begin
            mem_q[wr_ptr_q] <= '{dat: IN_DATA, zero: IN_ZERO, sfuop: IN_SFUOP};
        end
    end

endmodule

// File: tb/tb_sfu_out_buffer.sv
// Directed bench for sfu_out_buffer (DW=32, DEPTH=4) with hand-computed expectations.
module tb_sfu_out_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_zero, in_sfuop, in_ready;
    logic [31:0] in_data;
    logic        flush, out_valid, out_ready, out_zero, out_sfuop, overrun;
    logic [31:0] out_data;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fails  = 0;

    sfu_out_buffer #(.DW(32), .DEPTH(4)) dut (
        .CLK(clk), .RST_n(rst_n),
        .IN_VALID(in_valid), .IN_DATA(in_data), .IN_ZERO(in_zero), .IN_SFUOP(in_sfuop),
        .IN_READY(in_ready), .FLUSH(flush),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
        .OUT_ZERO(out_zero), .OUT_SFUOP(out_sfuop), .COUNT(count), .OVERRUN(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, take the edge, return #1 after it.
    task automatic cyc(input logic iv, input logic [31:0] d, input logic z, input logic op,
                       input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_zero   = z;
        in_sfuop  = op;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_check(input string tag, input logic [31:0] exp);
        check(tag, out_data, exp);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_zero = 1'b0; in_sfuop = 1'b0;
        out_ready = 1'b0; flush = 1'b0;
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two pushes with no consumer; head holds.
        push(32'h0000_0005);
        check("lat1_valid", 32'(out_valid), 32'd1);
        check("lat1_data", out_data, 32'h0000_0005);
        push(32'hFFFF_FFFB);
        check("two_count", 32'(count), 32'd2);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("two_hold", out_data, 32'h0000_0005);
        pop_check("two_pop0", 32'h0000_0005);
        pop_check("two_pop1", 32'hFFFF_FFFB);
        check("two_empty", 32'(out_valid), 32'd0);

        // Fill, overrun attempt, then push refused while popping at full.
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        check("full_in_ready", 32'(in_ready), 32'd0);
        push(32'hDEAD);
        check("full_count", 32'(count), 32'd4);
        check("full_overrun", 32'(overrun), 32'd1);
        check("full_head", out_data, 32'hA0);
        cyc(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0);
        check("full_pushpop_count", 32'(count), 32'd3);
        for (int i = 1; i < 4; i++) pop_check($sformatf("full_drain%0d", i), 32'hA0 + 32'(i));
        check("full_drained", 32'(count), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("flush_clr_overrun", 32'(overrun), 32'd0);

        // Streaming at COUNT=2 across pointer wrap.
        push(32'h100);
        push(32'h101);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("stream_data%0d", i), out_data, 32'h100 + 32'(i));
            cyc(1'b1, 32'h102 + 32'(i), 1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("stream_count%0d", i), 32'(count), 32'd2);
        end
        pop_check("stream_tail0", 32'h10A);
        pop_check("stream_tail1", 32'h10B);

        // Flag fields travel with the entry.
        cyc(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("flag_valid", 32'(out_valid), 32'd1);
        check("flag_zero", 32'(out_zero), 32'd1);
        check("flag_sfuop", 32'(out_sfuop), 32'd1);
        check("flag_data", out_data, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Flush overrides simultaneous push and pop, and clears OVERRUN.
        for (int i = 0; i < 4; i++) push(32'hC0 + 32'(i));
        push(32'hC4);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pre_flush_count", 32'(count), 32'd3);
        check("pre_flush_overrun", 32'(overrun), 32'd1);
        cyc(1'b1, 32'hC5, 1'b0, 1'b0, 1'b1, 1'b1);
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_overrun", 32'(overrun), 32'd0);
        push(32'hC6);
        check("post_flush_head", out_data, 32'hC6);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset between edges.
        push(32'hE0);
        push(32'hE1);
        push(32'hE2);
        check("pre_rst_count", 32'(count), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        push(32'h77);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_head", out_data, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sfu_out_buffer.md
SFU_OUT_BUFFER -- requirements
Module: sfu_out_buffer

Interface
REQ-001 The block SHALL have parameter DW, default 32, for result data width.
REQ-002 The block SHALL have parameter DEPTH, default 4, for entry count; it SHALL be a power of two, minimum 2.
REQ-003 The block SHALL have port CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RST_n  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port IN_VALID  in  1  sfu result valid this cycle.
REQ-006 The block SHALL have port IN_DATA  in  DW  sfu OUTPUT value.
REQ-007 The block SHALL have port IN_ZERO  in  1  sfu ZERO flag.
REQ-008 The block SHALL have port IN_SFUOP  in  1  sfu operation tag that produced the result.
REQ-009 The block SHALL have port IN_READY  out  1  buffer can accept an entry.
REQ-010 The block SHALL have port FLUSH  in  1  synchronous discard of all entries.
REQ-011 The block SHALL have port OUT_VALID  out  1  head entry present.
REQ-012 The block SHALL have port OUT_READY  in  1  consumer takes the head entry.
REQ-013 The block SHALL have port OUT_DATA  out  DW  head result.
REQ-014 The block SHALL have port OUT_ZERO  out  1  head ZERO flag.
REQ-015 The block SHALL have port OUT_SFUOP  out  1  head operation tag.
REQ-016 The block SHALL have port COUNT  out  log2(DEPTH)+1  occupied entries.
REQ-017 The block SHALL have port OVERRUN  out  1  sticky flag for a push attempted while full.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH entries {DATA, ZERO, SFUOP}, with write pointer, read pointer and COUNT registers.
REQ-019 A push SHALL occur when IN_VALID=1 and IN_READY=1 at a rising edge; the entry SHALL be written at the write pointer.
REQ-020 A pop SHALL occur when OUT_VALID=1 and OUT_READY=1 at a rising edge.
REQ-021 IN_READY SHALL equal (COUNT<DEPTH); it SHALL depend only on registered state, not on OUT_READY.
REQ-022 OUT_VALID SHALL equal (COUNT!=0).
REQ-023 OUT_DATA, OUT_ZERO and OUT_SFUOP SHALL combinationally present the entry at the read pointer (first-word fall-through).
REQ-024 Latency SHALL be one cycle: an entry pushed at edge N SHALL be visible on the outputs after edge N when the buffer was empty.
REQ-025 Outputs SHALL hold their values while OUT_VALID=1 and OUT_READY=0.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0 modulo DEPTH.
REQ-027 Simultaneous push and pop with 0<COUNT<DEPTH SHALL leave COUNT unchanged and advance both pointers.
REQ-028 Simultaneous push and pop at COUNT=0 SHALL NOT occur, since OUT_VALID=0; the push alone SHALL take effect.
REQ-029 At COUNT=DEPTH the push SHALL be refused even if OUT_READY=1 in the same cycle; the pop SHALL still occur.
REQ-030 IN_VALID=1 while IN_READY=0 SHALL set OVERRUN=1; OVERRUN SHALL clear only on reset or FLUSH.
REQ-031 FLUSH=1 SHALL, at the edge, set COUNT=0, both pointers=0 and OVERRUN=0, and SHALL override any simultaneous push or pop.
REQ-032 Entry contents SHALL NOT be reset; OUT_DATA is don't-care while OUT_VALID=0.

Reset
REQ-033 RST_n=0 SHALL immediately force COUNT=0, pointers=0 and OVERRUN=0, so that OUT_VALID=0 and IN_READY=1, independent of CLK.
REQ-034 Reset asserted mid-operation SHALL discard all entries; the first push after RST_n rises SHALL appear as the head.
REQ-035 RST_n deassertion SHALL be synchronised externally; the block SHALL resume on the first rising edge with RST_n=1.

Verification
REQ-036 Scenario: push 0x00000005/ZERO=0, then 0xFFFFFFFB/ZERO=0, with OUT_READY=0 -> COUNT=2; OUT_DATA=0x00000005 held.
REQ-037 Scenario: fill 4 entries, hold IN_VALID=1 for one more cycle with OUT_READY=0 -> IN_READY=0, COUNT=4, OVERRUN=1, no data lost.
REQ-038 Scenario: COUNT=2, IN_VALID=1 and OUT_READY=1 for 10 cycles -> COUNT stays 2, outputs in push order, pointer wrap exercised.
REQ-039 Scenario: push 0x00000000/ZERO=1/SFUOP=1 into an empty buffer -> after one edge OUT_VALID=1, OUT_ZERO=1, OUT_SFUOP=1.
REQ-040 Scenario: COUNT=3 with FLUSH=1, IN_VALID=1 and OUT_READY=1 together -> next cycle COUNT=0, OUT_VALID=0, OVERRUN=0.
REQ-041 Scenario: COUNT=3, RST_n pulsed low between edges -> OUT_VALID=0 immediately; a push after release yields COUNT=1 with the new data at the head.
